// File: rtl/template_loader.sv
// Template loader: captures a TW x TW window from the frame BRAM into a shadow buffer
// and commits it atomically to template_reg. Optional macro TEMPLATE_BLEND_EN averages successive templates.
module template_loader #(
  parameter int TW         = 16,
  parameter int VGA_WIDTH  = 640,
  parameter int VGA_HEIGHT = 480,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture_req,
  input  logic [9:0]           center_x,
  input  logic [9:0]           center_y,
  output logic [18:0]          bram_addr,
  input  logic [3:0]           bram_data,
  output logic [TW*TW*4-1:0]   template_reg,
  output logic                 template_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int N  = TW * TW;
  localparam int CW = $clog2(TW);
  localparam int IW = $clog2(N);

  localparam logic [9:0] HALF  = 10'(TW / 2);
  localparam logic [9:0] X_HI  = 10'(VGA_WIDTH - TW / 2);
  localparam logic [9:0] X_ORG = 10'(VGA_WIDTH - TW);
  localparam logic [9:0] Y_HI  = 10'(VGA_HEIGHT - TW / 2);
  localparam logic [9:0] Y_ORG = 10'(VGA_HEIGHT - TW);
  localparam logic [RD_LATENCY-1:0] VP_LAST = RD_LATENCY'(1) << (RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

  state_t                state, state_next;
  logic                  accept, issue, commit;
  logic [9:0]            ox, oy, ox_next, oy_next;
  logic [CW-1:0]         row, col;
  logic                  last_pix;
  logic [18:0]           addr_next;
  logic [RD_LATENCY-1:0] vpipe;
  logic [IW-1:0]         wr_idx;
  logic [N*4-1:0]        shadow;
  logic [N*4-1:0]        commit_val;

  always_comb begin
    if (center_x < HALF)      ox_next = '0;
    else if (center_x > X_HI) ox_next = X_ORG;
    else                      ox_next = center_x - HALF;
    if (center_y < HALF)      oy_next = '0;
    else if (center_y > Y_HI) oy_next = Y_ORG;
    else                      oy_next = center_y - HALF;
  end

  assign last_pix  = (row == CW'(TW - 1)) && (col == CW'(TW - 1));
  assign addr_next = (19'(oy) + 19'(row)) * 19'(VGA_WIDTH) + 19'(ox) + 19'(col);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // DRAIN ends when only the oldest pipeline slot is still valid: that sample lands this edge.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: if (capture_req) begin
        accept     = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (last_pix) state_next = DRAIN;
      end
      DRAIN: if (vpipe == VP_LAST) state_next = COMMIT;
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef TEMPLATE_BLEND_EN
  always_comb begin
    logic [4:0] sum;
    sum        = '0;
    commit_val = shadow;
    if (template_valid) begin
      for (int unsigned p = 0; p < N; p++) begin
        sum = {1'b0, template_reg[p*4 +: 4]} + {1'b0, shadow[p*4 +: 4]} + 5'd1;
        commit_val[p*4 +: 4] = sum[4:1];
      end
    end
  end
`else
  always_comb commit_val = shadow;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bram_addr      <= '0;
      template_reg   <= '0;
      template_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      shadow         <= '0;
      ox             <= '0;
      oy             <= '0;
      row            <= '0;
      col            <= '0;
      wr_idx         <= '0;
      vpipe          <= '0;
    end else begin
      done  <= commit;
      vpipe <= (vpipe << 1) | RD_LATENCY'(issue);
      if (accept) begin
        ox     <= ox_next;
        oy     <= oy_next;
        row    <= '0;
        col    <= '0;
        wr_idx <= '0;
        busy   <= 1'b1;
      end else if (commit) begin
        busy <= 1'b0;
      end
      if (issue) begin
        bram_addr <= addr_next;
        if (col == CW'(TW - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (vpipe[RD_LATENCY-1]) begin
        shadow[int'(wr_idx)*4 +: 4] <= bram_data;
        wr_idx <= wr_idx + 1'b1;
      end
      if (commit) begin
        template_reg   <= commit_val;
        template_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/template_loader.md
Name: template_loader

Overview:
- Upstream feeder for the correlator's template input.
- On request, reads a TW x TW pixel window from the static frame BRAM, centred on a given coordinate, into a shadow buffer.
- Commits the window atomically to the template register output, so the correlator never sees a half-updated template.
- Sits between the tracking control logic (which supplies the centre point and request) and the correlator.

Parameters:
- TW, 16, template width/height in pixels; must be even.
- VGA_WIDTH, 640, frame width in pixels.
- VGA_HEIGHT, 480, frame height in pixels.
- RD_LATENCY, 2, BRAM read latency in clocks, from address to data (1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- capture_req  in  1  request a template capture; sampled only in IDLE
- center_x  in  10  window centre column
- center_y  in  10  window centre row
- bram_addr  out  19  static BRAM read address, registered
- bram_data  in  4  BRAM read data, valid RD_LATENCY clocks after its address
- template_reg  out  TW*TW*4  packed [row][col][3:0]; pixel (r,c) at bits ((r*TW+c)*4)+:4
- template_valid  out  1  high once any template has been committed
- busy  out  1  high from acceptance until commit inclusive
- done  out  1  one-cycle pulse on the commit edge

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset: state=IDLE, bram_addr=0, template_reg=0, shadow=0, template_valid=0, busy=0, done=0, all counters and the valid pipeline cleared. Reset mid-capture aborts the capture; nothing is committed.
- Origin clamping, computed at acceptance and latched:
  - ox = 0 if center_x < TW/2; VGA_WIDTH-TW if center_x > VGA_WIDTH-TW/2; else center_x-TW/2.
  - oy is computed the same way against VGA_HEIGHT.
- State IDLE: capture_req=1 at edge E0 latches ox/oy, sets busy=1, moves to ISSUE.
- State ISSUE:
  - At edges E1..E(TW*TW), bram_addr = (oy+r)*VGA_WIDTH + (ox+c) for pixel k-1, in row-major order (c increments; wraps to 0 with r+1 at c=TW-1).
  - A 1-bit valid shift pipeline of depth RD_LATENCY tracks issued addresses.
  - After the last address is issued, move to DRAIN; bram_addr holds its last value.
- State DRAIN: continues until the valid pipeline is empty.
- Data capture: whenever the pipeline output is valid, bram_data is written into shadow[wr_idx] and wr_idx increments. wr_idx is independent of the issue counter.
- State COMMIT:
  - Entered after the final sample at edge E(TW*TW+RD_LATENCY).
  - At edge E(TW*TW+RD_LATENCY+1): template_reg <= shadow, template_valid=1, done=1 for one cycle, busy=0, return to IDLE.
- Latency: capture_req acceptance to done = TW*TW + RD_LATENCY + 1 edges (259 for the defaults).
- Request handling:
  - capture_req while busy (ISSUE/DRAIN/COMMIT) is ignored, not queued.
  - capture_req held high re-triggers in the cycle after COMMIT.
- Stability: center_x/center_y changes during a capture have no effect. template_reg changes only on the commit edge or on reset.
- Widths: address arithmetic uses 19-bit unsigned; the maximum address (479*640+639 = 307199) fits.

Optional Feature:
- Macro: TEMPLATE_BLEND_EN.
- Defined: at commit, if template_valid is already 1, each pixel = (old + new + 1) >> 1, computed in 5 bits and truncated to 4. The first commit after reset is a direct copy.
- Not defined: every commit is a direct copy of shadow.

Test Plan:
- BRAM model with data = addr[3:0], RD_LATENCY=2, capture at (320,240) -> origin (312,232); pixel(0,0)=(232*640+312)&0xF=8; done exactly 259 edges after acceptance; template_valid=1.
- Capture at (3,2) -> origin (0,0), first bram_addr=0; capture at (639,479) -> origin (624,464), last bram_addr=479*640+639=307199.
- capture_req pulsed at edges E0, E50 and E258 -> only one done; busy stays 1 throughout; template_reg unchanged until E259.
- rst_n low at edge E100 of a capture -> busy=0, template_valid=0, template_reg=0, no done pulse; a new capture afterwards completes normally.
- With RD_LATENCY=1 and RD_LATENCY=4 -> done at 258 and 261 edges respectively; all pixels correct.
- TEMPLATE_BLEND_EN defined: first capture with all pixels 0xF, second with all pixels 0x0 -> template pixels 0x8; undefined -> 0x0.
